// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory stage: load/store codes, block
// geometry and the cache controller state encoding.
package dmem_pkg;

  localparam logic [2:0] NONE   = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LH  = 3'b010;
  localparam logic [2:0] LD_LW  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;
  localparam logic [2:0] ST_SB  = 3'b001;
  localparam logic [2:0] ST_SH  = 3'b010;
  localparam logic [2:0] ST_SW  = 3'b011;

  localparam int BLOCK_BYTES = 16;
  localparam int OFFSET_BITS = $clog2(BLOCK_BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE_BACK,
    S_ALLOCATE
  } state_t;

  function automatic logic is_load(input logic [2:0] code);
    return (code != NONE) && (code <= LD_LHU);
  endfunction

  function automatic logic is_store(input logic [2:0] code);
    return (code != NONE) && (code <= ST_SW);
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Selects the addressed byte/halfword/word from a 128-bit cache line and
// applies sign or zero extension according to the load code.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [127:0] line_data,
  input  logic [1:0]   word_sel,
  input  logic [1:0]   byte_sel,
  input  logic [2:0]   load_code,
  output logic [31:0]  load_data
);

  logic [31:0] word_val;
  logic [15:0] half_val;
  logic [7:0]  byte_val;

  assign word_val = line_data[{word_sel, 5'd0} +: 32];
  assign byte_val = word_val[{byte_sel, 3'd0} +: 8];
  assign half_val = byte_sel[1] ? word_val[31:16] : word_val[15:0];

  always_comb begin
    load_data = '0;
    case (load_code)
      LD_LB:   load_data = {{24{byte_val[7]}}, byte_val};
      LD_LBU:  load_data = {24'd0, byte_val};
      LD_LH:   load_data = {{16{half_val[15]}}, half_val};
      LD_LHU:  load_data = {16'd0, half_val};
      LD_LW:   load_data = word_val;
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Stalls the pipeline through BUSY_WAIT while a miss is serviced.
module dmem_cache_ctrl
  import dmem_pkg::*;
#(
  parameter int NUM_LINES = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [2:0]   MEM_READ,
  input  logic [2:0]   MEM_WRITE,
  input  logic [31:0]  ADDRESS,
  input  logic [31:0]  WRITE_DATA,
  output logic [31:0]  READ_DATA,
  output logic         BUSY_WAIT,
  output logic         MAIN_MEM_READ,
  output logic         MAIN_MEM_WRITE,
  output logic [27:0]  MAIN_MEM_ADDRESS,
  output logic [127:0] MAIN_MEM_WRITE_DATA,
  input  logic [127:0] MAIN_MEM_READ_DATA,
  input  logic         MAIN_MEM_BUSY_WAIT
);

  localparam int INDEX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS   = 32 - OFFSET_BITS - INDEX_BITS;

  logic [TAG_BITS-1:0]   tag;
  logic [INDEX_BITS-1:0] index;
  logic [1:0]            word_sel;
  logic [1:0]            byte_sel;

  assign tag      = ADDRESS[31:OFFSET_BITS+INDEX_BITS];
  assign index    = ADDRESS[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign word_sel = ADDRESS[3:2];
  assign byte_sel = ADDRESS[1:0];

  logic [NUM_LINES-1:0] valid_reg;
  logic [NUM_LINES-1:0] dirty_reg;
  logic [TAG_BITS-1:0]  tag_mem  [NUM_LINES];
  logic [127:0]         data_mem [NUM_LINES];

  state_t state_reg, state_next;

  logic         wr_req, rd_req, hit;
  logic         refill_en, store_en;
  logic [127:0] line_data, merged_line;
  logic [31:0]  load_data;
  logic [3:0]   lane_mask;
  logic [31:0]  store_lanes;

  // A store takes precedence when both codes are presented.
  assign wr_req    = is_store(MEM_WRITE);
  assign rd_req    = !wr_req && is_load(MEM_READ);
  assign line_data = data_mem[index];
  assign hit       = valid_reg[index] && (tag_mem[index] == tag);
  assign refill_en = (state_reg == S_ALLOCATE) && !MAIN_MEM_BUSY_WAIT;
  assign store_en  = (state_reg == S_IDLE) && wr_req && hit;

  dmem_load_align u_align (
    .line_data (line_data),
    .word_sel  (word_sel),
    .byte_sel  (byte_sel),
    .load_code (MEM_READ),
    .load_data (load_data)
  );

  assign READ_DATA = ((state_reg == S_IDLE) && rd_req && hit) ? load_data : '0;

  // Store data is replicated across lanes so each byte lane picks its own slice.
  always_comb begin
    lane_mask   = 4'b0000;
    store_lanes = WRITE_DATA;
    case (MEM_WRITE)
      ST_SB: begin
        lane_mask   = 4'b0001 << byte_sel;
        store_lanes = {4{WRITE_DATA[7:0]}};
      end
      ST_SH: begin
        lane_mask   = byte_sel[1] ? 4'b1100 : 4'b0011;
        store_lanes = {2{WRITE_DATA[15:0]}};
      end
      ST_SW:   lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < BLOCK_BYTES; gi++) begin : g_merge
      localparam logic [1:0] WORD_ID = 2'(gi / 4);
      assign merged_line[gi*8 +: 8] = (lane_mask[gi % 4] && (word_sel == WORD_ID))
                                      ? store_lanes[(gi % 4)*8 +: 8]
                                      : line_data[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    state_next          = state_reg;
    BUSY_WAIT           = 1'b0;
    MAIN_MEM_READ       = 1'b0;
    MAIN_MEM_WRITE      = 1'b0;
    MAIN_MEM_ADDRESS    = '0;
    MAIN_MEM_WRITE_DATA = '0;
    case (state_reg)
      S_IDLE: begin
        if ((wr_req || rd_req) && !hit) begin
          BUSY_WAIT  = 1'b1;
          state_next = (valid_reg[index] && dirty_reg[index]) ? S_WRITE_BACK : S_ALLOCATE;
        end
      end
      S_WRITE_BACK: begin
        BUSY_WAIT           = 1'b1;
        MAIN_MEM_WRITE      = 1'b1;
        MAIN_MEM_ADDRESS    = {tag_mem[index], index};
        MAIN_MEM_WRITE_DATA = line_data;
        if (!MAIN_MEM_BUSY_WAIT) state_next = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        BUSY_WAIT        = 1'b1;
        MAIN_MEM_READ    = 1'b1;
        MAIN_MEM_ADDRESS = {tag, index};
        if (!MAIN_MEM_BUSY_WAIT) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= S_IDLE;
      valid_reg <= '0;
      dirty_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (refill_en) begin
        valid_reg[index] <= 1'b1;
        dirty_reg[index] <= 1'b0;
      end else if (store_en) begin
        dirty_reg[index] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; a refill cut short by reset is dropped.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (refill_en) begin
        data_mem[index] <= MAIN_MEM_READ_DATA;
        tag_mem[index]  <= tag;
      end else if (store_en) begin
        data_mem[index] <= merged_line;
      end
    end
  end

endmodule

// File: doc/dmem_cache_ctrl.md
Name: dmem_cache_ctrl

Overview:
- Data-memory stage of the 5-stage RISC-V pipeline; sits directly downstream of the EX/MEM pipeline register.
- Inputs it consumes from that register: ALU result (used as the address), store operand, and the 3-bit load/store codes.
- Implements a direct-mapped, write-back, write-allocate data cache with 16-byte blocks.
- Raises BUSY_WAIT to stall every pipeline register while a miss is serviced against a multi-cycle main memory.

Parameters:
- NUM_LINES, 8, number of cache lines; power of two ≥ 2. INDEX_BITS = log2(NUM_LINES); TAG_BITS = 28 − INDEX_BITS.

Ports:
- CLK  in  1  pipeline clock.
- RESET  in  1  synchronous, active-high reset.
- MEM_READ  in  3  load code: 000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU; 110/111 treated as none.
- MEM_WRITE  in  3  store code: 000 none, 001 SB, 010 SH, 011 SW; others treated as none.
- ADDRESS  in  32  byte address, taken from ALU_RESULT.
- WRITE_DATA  in  32  store operand (rs2 value).
- READ_DATA  out  32  load result, already sign- or zero-extended.
- BUSY_WAIT  out  1  stall request to all pipeline registers and the PC.
- MAIN_MEM_READ  out  1  block-read request.
- MAIN_MEM_WRITE  out  1  block-write request.
- MAIN_MEM_ADDRESS  out  28  block address (byte address >> 4).
- MAIN_MEM_WRITE_DATA  out  128  block being evicted.
- MAIN_MEM_READ_DATA  in  128  fetched block.
- MAIN_MEM_BUSY_WAIT  in  1  main memory busy; low means the current request completes at this edge.

Behaviour:
- Address split:
  - tag = ADDRESS[31:4+INDEX_BITS]; index = ADDRESS[3+INDEX_BITS:4].
  - word = ADDRESS[3:2]; byte = ADDRESS[1:0].
  - Halfword accesses ignore ADDRESS[0]; word accesses ignore ADDRESS[1:0]. No misalignment trap.
- Storage per line: valid, dirty, tag, 128-bit data.
- Request: present when MEM_READ or MEM_WRITE is a legal non-none code. If both are present, the write wins and the read is ignored.
- hit = valid[index] && tag match.
- FSM states: IDLE, WRITE_BACK, ALLOCATE.
- IDLE:
  - No request: BUSY_WAIT = 0.
  - Read hit: READ_DATA is valid combinationally in the same cycle; BUSY_WAIT = 0.
  - Write hit: the addressed bytes are updated at the next posedge and dirty is set; BUSY_WAIT = 0.
  - Miss: BUSY_WAIT = 1 combinationally in the same cycle. Next state is WRITE_BACK if the line is valid && dirty, otherwise ALLOCATE.
- WRITE_BACK:
  - Drives MAIN_MEM_WRITE = 1, MAIN_MEM_ADDRESS = {old tag, index}, MAIN_MEM_WRITE_DATA = line data.
  - Moves to ALLOCATE on a posedge where MAIN_MEM_BUSY_WAIT = 0.
- ALLOCATE:
  - Drives MAIN_MEM_READ = 1, MAIN_MEM_ADDRESS = {tag, index}.
  - On a posedge where MAIN_MEM_BUSY_WAIT = 0: load the line, set valid = 1, dirty = 0, write the tag, go to IDLE.
- After refill:
  - The request is re-evaluated in IDLE as a hit, so BUSY_WAIT falls in the cycle after the refill edge.
  - A refilled store line becomes dirty at the following edge.
- Main-memory strobes are never both high. Each strobe stays asserted from state entry until the completing edge.
- BUSY_WAIT is 1 in WRITE_BACK and ALLOCATE regardless of inputs.
- Load formatting:
  - LB / LBU: selected byte, sign-/zero-extended.
  - LH / LHU: selected halfword, sign-/zero-extended.
  - LW: full word.
  - READ_DATA = 0 when there is no read hit in IDLE.
- Store merge: SB writes 1 byte lane, SH writes 2 byte lanes, SW writes all 4; all other bytes are preserved.
- Reset (synchronous, highest priority):
  - All valid and dirty bits cleared; FSM to IDLE; data/tag arrays not cleared.
  - Outputs after the reset edge: BUSY_WAIT = 0, strobes = 0, MAIN_MEM_ADDRESS = 0, MAIN_MEM_WRITE_DATA = 0, READ_DATA = 0.
  - Reset mid-WRITE_BACK or mid-ALLOCATE drops both strobes at that edge, and the partial transaction is abandoned.
- Inputs are held stable by the upstream register while BUSY_WAIT = 1; changes during a miss are not supported.

Decomposition:
- Shared package `dmem_pkg` holds:
  - load/store code localparams (LD_LB…LD_LHU, ST_SB…ST_SW, NONE);
  - FSM state encoding;
  - BLOCK_BYTES = 16.
- One natural sub-module, `dmem_load_align`: combinational byte/halfword select plus sign/zero extension from the 128-bit line, word, byte and load code. It is reused by the load unit's forwarding path.

Test Plan:
- Cold LW 0x0000_0040, main memory returns 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA after 5 busy cycles -> BUSY_WAIT high for 7 cycles, MAIN_MEM_READ with address 0x0000004, then READ_DATA = 0xAAAAAAAA and BUSY_WAIT = 0.
- Hit LB on byte 0x43 = 0x8F -> READ_DATA = 0xFFFFFF8F the same cycle; LBU -> 0x0000008F; LHU 0x42 with 0x8F7E -> 0x00008F7E.
- SB 0x41 data 0x12345677 on a resident line, then LW 0x40 -> byte lane 1 = 0x77, other bytes unchanged, dirty = 1, no BUSY_WAIT.
- Dirty line at index 4, then LW 0x0000_00C0 (same index, new tag) -> MAIN_MEM_WRITE to block 0x0000004 with the old data, then MAIN_MEM_READ to block 0x000000C; strobes never overlap.
- RESET asserted during the 3rd ALLOCATE cycle -> strobes and BUSY_WAIT low after that edge; a subsequent LW to the same address misses again.
- MEM_READ = 011 and MEM_WRITE = 011 together on a hit -> store performed, READ_DATA = 0.
